// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - IF stage: PC, loadable instruction memory, IF/ID register (optional macro STEP_MODE_EN adds i_step)
module instruction_fetch #(
   parameter int                N_BITS      = 32,
   parameter int                N_ADDR_BITS = 8,
   parameter logic [N_BITS-1:0] PC_RESET    = '0
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_start,
   input  logic                   i_load_valid,
   input  logic [N_ADDR_BITS-1:0] i_load_addr,
   input  logic [N_BITS-1:0]      i_load_data,
   output logic                   o_load_ready,
   input  logic                   i_stall,
   input  logic                   i_flush,
   input  logic [N_BITS-1:0]      i_jump_direction,
   input  logic                   i_halt,
`ifdef STEP_MODE_EN
   input  logic                   i_step,
`endif
   output logic [N_BITS-1:0]      o_instruccion,
   output logic [N_BITS-1:0]      o_pc_4,
   output logic                   o_valid,
   output logic [N_BITS-1:0]      o_pc,
   output logic                   o_halted
);

   localparam int DEPTH = 2 ** N_ADDR_BITS;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [N_BITS-1:0]   pc_q, pc_d;
   logic [N_BITS-1:0]   instr_q, instr_d;
   logic [N_BITS-1:0]   pc_4_q, pc_4_d;
   logic                valid_q, valid_d;
   logic                load_ready_q, load_ready_d;
   logic                halted_q, halted_d;

   // Instruction memory is deliberately left out of reset so a loaded program survives it
   logic [N_BITS-1:0]   mem [DEPTH];

   logic [N_BITS-1:0]   fetch_word;
   logic [N_BITS-1:0]   pc_plus_4;
   logic                load_we;
   logic                advance_en;

   // Combinational fetch: word index drops PC[1:0] and wraps modulo memory depth
   assign fetch_word = mem[pc_q[N_ADDR_BITS+1:2]];
   assign pc_plus_4  = pc_q + N_BITS'(4);
   assign load_we    = load_ready_q & i_load_valid;

`ifdef STEP_MODE_EN
   assign advance_en = ~i_stall & i_step;
`else
   assign advance_en = ~i_stall;
`endif

   // Next-state logic: in RUN the priority is halt > flush > stall/no-step > advance
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      instr_d      = instr_q;
      pc_4_d       = pc_4_q;
      valid_d      = valid_q;
      load_ready_d = load_ready_q;
      halted_d     = halted_q;

      unique case (state_q)
         ST_IDLE: begin
            instr_d = '0;
            pc_4_d  = '0;
            valid_d = 1'b0;
            if (i_start) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (i_halt) begin
               state_d = ST_HALTED;
               instr_d = '0;
               pc_4_d  = '0;
               valid_d = 1'b0;
            end else if (i_flush) begin
               pc_d    = i_jump_direction;
               instr_d = '0;
               pc_4_d  = '0;
               valid_d = 1'b0;
            end else if (advance_en) begin
               instr_d = fetch_word;
               pc_4_d  = pc_plus_4;
               valid_d = 1'b1;
               pc_d    = pc_plus_4;
            end
         end
         ST_HALTED: begin
            instr_d = '0;
            pc_4_d  = '0;
            valid_d = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      load_ready_d = (state_d == ST_IDLE);
      halted_d     = (state_d == ST_HALTED);
   end

   // FSM state, PC and IF/ID register, with synchronous active-high reset
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q      <= ST_IDLE;
         pc_q         <= PC_RESET;
         instr_q      <= '0;
         pc_4_q       <= '0;
         valid_q      <= 1'b0;
         load_ready_q <= 1'b1;
         halted_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         pc_4_q       <= pc_4_d;
         valid_q      <= valid_d;
         load_ready_q <= load_ready_d;
         halted_q     <= halted_d;
      end
   end

   // Loader write port: only accepted while IDLE, so it never collides with a fetch
   always_ff @(posedge i_clk) begin
      if (!i_reset && load_we) begin
         mem[i_load_addr] <= i_load_data;
      end
   end

   assign o_instruccion = instr_q;
   assign o_pc_4        = pc_4_q;
   assign o_valid       = valid_q;
   assign o_pc          = pc_q;
   assign o_halted      = halted_q;
   assign o_load_ready  = load_ready_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench for instruction_fetch
module tb_instruction_fetch;

   logic        clk;
   logic        i_reset;
   logic        i_start;
   logic        i_load_valid;
   logic [7:0]  i_load_addr;
   logic [31:0] i_load_data;
   logic        o_load_ready;
   logic        i_stall;
   logic        i_flush;
   logic [31:0] i_jump_direction;
   logic        i_halt;
   logic        i_step;
   logic [31:0] o_instruccion;
   logic [31:0] o_pc_4;
   logic        o_valid;
   logic [31:0] o_pc;
   logic        o_halted;

   instruction_fetch #(.N_BITS(32), .N_ADDR_BITS(8), .PC_RESET(32'h0)) dut (
      .i_clk            (clk),
      .i_reset          (i_reset),
      .i_start          (i_start),
      .i_load_valid     (i_load_valid),
      .i_load_addr      (i_load_addr),
      .i_load_data      (i_load_data),
      .o_load_ready     (o_load_ready),
      .i_stall          (i_stall),
      .i_flush          (i_flush),
      .i_jump_direction (i_jump_direction),
      .i_halt           (i_halt),
`ifdef STEP_MODE_EN
      .i_step           (i_step),
`endif
      .o_instruccion    (o_instruccion),
      .o_pc_4           (o_pc_4),
      .o_valid          (o_valid),
      .o_pc             (o_pc),
      .o_halted         (o_halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        valid;
      logic        halted;
      logic        ready;
   } status_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc4;
   } fetch_t;

   status_t st_q[$];
   fetch_t  fetch_q[$];

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: program memory plus architectural state of the fetch stage
   logic [31:0] mem_m [256];
   bit          m_run, m_halt;
   logic [31:0] m_pc, m_instr, m_pc4;
   bit          m_valid;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Applies the behavioural rules to the inputs seen at the edge just taken
   task automatic model_step();
      bit step_v;
`ifdef STEP_MODE_EN
      step_v = i_step;
`else
      step_v = 1'b1;
`endif
      if (i_reset) begin
         m_run = 0; m_halt = 0; m_pc = 32'h0;
         m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 0;
      end else if (m_halt) begin
         // frozen until reset
      end else if (!m_run) begin
         if (i_load_valid) mem_m[i_load_addr] = i_load_data;
         if (i_start) m_run = 1;
      end else if (i_halt) begin
         m_halt = 1; m_run = 0; m_instr = 32'h0; m_valid = 0;
      end else if (i_flush) begin
         m_pc = i_jump_direction; m_instr = 32'h0; m_valid = 0;
      end else if (i_stall || !step_v) begin
         // hold
      end else begin
         m_instr = mem_m[(m_pc / 4) % 256];
         m_pc4   = m_pc + 32'd4;
         m_valid = 1;
         m_pc    = m_pc + 32'd4;
         fetch_q.push_back('{instr: m_instr, pc4: m_pc4});
      end
      st_q.push_back('{instr: m_instr, pc: m_pc, valid: m_valid,
                       halted: m_halt, ready: (!m_run && !m_halt)});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_step();
   endtask

   task automatic clear_inputs();
      i_reset = 0; i_start = 0; i_load_valid = 0; i_load_addr = 8'h0;
      i_load_data = 32'h0; i_stall = 0; i_flush = 0; i_jump_direction = 32'h0;
      i_halt = 0; i_step = 1;
   endtask

   task automatic load_word(input logic [7:0] a, input logic [31:0] d, input bit st);
      clear_inputs();
      i_load_valid = 1; i_load_addr = a; i_load_data = d; i_start = st;
      tick();
   endtask

   // Monitor: per-cycle status compare, plus a fetch compare whenever a new instruction appears
   bit          prev_valid = 0;
   logic [31:0] prev_pc4 = 32'h0;
   initial begin
      forever begin
         @(negedge clk);
         if (st_q.size() > 0) begin
            status_t e;
            e = st_q.pop_front();
            chk("instr",      o_instruccion,        e.instr);
            chk("pc",         o_pc,                 e.pc);
            chk("valid",      {31'b0, o_valid},     {31'b0, e.valid});
            chk("halted",     {31'b0, o_halted},    {31'b0, e.halted});
            chk("load_ready", {31'b0, o_load_ready},{31'b0, e.ready});
         end
         if (o_valid === 1'b1 && (!prev_valid || o_pc_4 !== prev_pc4)) begin
            if (fetch_q.size() == 0) begin
               chk("unexpected_fetch_pc4", o_pc_4, 32'hXXXXXXXX);
            end else begin
               fetch_t f;
               f = fetch_q.pop_front();
               chk("fetch_instr", o_instruccion, f.instr);
               chk("fetch_pc4",   o_pc_4,        f.pc4);
            end
         end
         prev_valid = (o_valid === 1'b1);
         prev_pc4   = o_pc_4;
      end
   end

   initial begin
      clear_inputs();
      i_reset = 1;
      tick();
      tick();

      // Fill the whole memory, then the directed program words
      for (int a = 0; a < 256; a++) load_word(8'(a), $urandom, 0);
      load_word(8'd16, 32'hDEAD_0010, 0);
      load_word(8'd0,  32'h2001_0005, 0);
      load_word(8'd1,  32'h2002_0003, 0);
      load_word(8'd2,  32'h0022_1820, 1);   // load together with start

      // Three advances, stall for two cycles on mem[1], then resume
      clear_inputs();
      tick(); tick();
      i_stall = 1; tick(); tick();
      i_stall = 0; tick();

      // Flush beats stall; then two fetches from 0x40
      i_flush = 1; i_stall = 1; i_jump_direction = 32'h40; tick();
      clear_inputs(); tick(); tick();

      // Halt, then pound on start/load/flush for ten cycles
      i_halt = 1; tick();
      for (int k = 0; k < 10; k++) begin
         clear_inputs();
         i_start = k[0]; i_load_valid = ~k[0]; i_load_addr = 8'd0;
         i_load_data = 32'hBAD0_0000; i_flush = k[1]; i_jump_direction = 32'h80;
         tick();
      end

      // Reset keeps memory; run again, try loading during RUN, wrap via 0x400 and PC top
      clear_inputs(); i_reset = 1; tick();
      clear_inputs(); i_start = 1; tick();
      clear_inputs(); tick();
      i_load_valid = 1; i_load_addr = 8'd1; i_load_data = 32'hBAD1_1111; tick();
      clear_inputs(); i_flush = 1; i_jump_direction = 32'h400; tick();
      clear_inputs(); tick(); tick();
      i_flush = 1; i_jump_direction = 32'hFFFF_FFF8; tick();
      clear_inputs(); tick(); tick(); tick();

      // Step-mode pattern: step every third cycle, with a flush during step=0
      for (int k = 0; k < 12; k++) begin
         clear_inputs();
         i_step = (k % 3 == 0);
         if (k == 7) begin i_flush = 1; i_jump_direction = 32'h20; end
         tick();
      end

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         clear_inputs();
         i_reset          = ($urandom_range(0, 299) == 0);
         i_start          = ($urandom_range(0, 7) == 0);
         i_load_valid     = $urandom_range(0, 1);
         i_load_addr      = 8'($urandom);
         i_load_data      = $urandom;
         i_halt           = ($urandom_range(0, 199) == 0);
         i_flush          = ($urandom_range(0, 11) == 0);
         i_stall          = ($urandom_range(0, 4) == 0);
         i_step           = ($urandom_range(0, 2) != 0);
         case ($urandom_range(0, 3))
            0: i_jump_direction = 32'h400;
            1: i_jump_direction = 32'hFFFF_FFFC;
            2: i_jump_direction = $urandom_range(0, 1023);
            default: i_jump_direction = $urandom;
         endcase
         tick();
      end

      clear_inputs();
      @(negedge clk);
      #1;
      chk("fetch_queue_drained", 32'(fetch_q.size()), 32'd0);
      chk("status_queue_drained", 32'(st_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
